// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - SDRAM init command encodings, sequencer state type and mode-word builder
package sdram_pkg;

  typedef logic [3:0] sdram_cmd_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam sdram_cmd_t CMD_NOP  = 4'b0111;
  localparam sdram_cmd_t CMD_PRE  = 4'b0010;
  localparam sdram_cmd_t CMD_AREF = 4'b0001;
  localparam sdram_cmd_t CMD_MRS  = 4'b0000;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_PRE,
    ST_TRP,
    ST_AR,
    ST_TRFC,
    ST_MRS,
    ST_TMRD,
    ST_DONE
  } init_state_t;

  // Low ten address bits of a LOAD MODE REGISTER command; upper bits are zero.
  function automatic logic [9:0] build_mode(input logic       wr_burst,
                                            input logic [2:0] cl,
                                            input logic       bt,
                                            input logic [2:0] bl);
    return {wr_burst, 2'b00, cl, bt, bl};
  endfunction

endpackage

// File: rtl/sdram_timer.sv
// rtl/sdram_timer.sv - loadable down-counter with done flag for tRP/tRFC/tMRD spacing
module sdram_timer #(
  parameter int CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sdram_init_gen.sv
// rtl/sdram_init_gen.sv - SDRAM power-up init sequencer with reinit and mode-reload handshakes
module sdram_init_gen
  import sdram_pkg::*;
#(
  parameter int         T_WAIT     = 20000,
  parameter int         AR_NUM     = 8,
  parameter int         TRP        = 2,
  parameter int         TRFC       = 7,
  parameter int         TMRD       = 3,
  parameter int         ADDR_W     = 13,
  parameter int         BANK_W     = 2,
  parameter logic [2:0] CAS_LAT    = 3'd3,
  parameter logic [2:0] BURST_LEN  = 3'b111,
  parameter logic       BURST_TYPE = 1'b0,
  parameter logic       WR_BURST   = 1'b0
) (
  input  logic              init_clk,
  input  logic              init_rst_n,
  input  logic              reinit_req,
  output logic              reinit_ack,
  input  logic              mrs_req,
  input  logic [2:0]        mrs_cl,
  input  logic [2:0]        mrs_bl,
  output logic              mrs_ack,
  output logic [3:0]        init_cmd,
  output logic [ADDR_W-1:0] init_addr,
  output logic [BANK_W-1:0] init_bank,
  output logic              init_end,
  output logic [2:0]        cur_cl
);

  localparam int T_MAX  = (TRP > TRFC) ? ((TRP > TMRD) ? TRP : TMRD)
                                       : ((TRFC > TMRD) ? TRFC : TMRD);
  localparam int CNT_W  = $clog2(T_MAX + 1);
  localparam int WAIT_W = $clog2(T_WAIT + 1);
  localparam int AR_W   = $clog2(AR_NUM + 1);

  init_state_t       r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [AR_W-1:0]   r_ar_cnt;
  logic [2:0]        r_mode_cl;
  logic [2:0]        r_mode_bl;
  sdram_cmd_t        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [BANK_W-1:0] r_bank;
  logic              r_init_end;
  logic              r_reinit_ack;
  logic              r_mrs_ack;

  logic              w_tmr_load;
  logic [CNT_W-1:0]  w_tmr_val;
  logic              w_tmr_done;

  // Timer is armed in each command state so the following wait state lasts exactly N cycles.
  always_comb begin
    w_tmr_load = 1'b1;
    w_tmr_val  = CNT_W'(TRP - 1);
    case (r_state)
      ST_PRE:  w_tmr_val = CNT_W'(TRP - 1);
      ST_AR:   w_tmr_val = CNT_W'(TRFC - 1);
      ST_MRS:  w_tmr_val = CNT_W'(TMRD - 1);
      default: w_tmr_load = 1'b0;
    endcase
  end

  sdram_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk   (init_clk),
    .i_rst_n (init_rst_n),
    .i_load  (w_tmr_load),
    .i_val   (w_tmr_val),
    .o_done  (w_tmr_done)
  );

  always_ff @(posedge init_clk or negedge init_rst_n) begin
    if (!init_rst_n) begin
      r_state      <= ST_WAIT;
      r_wait_cnt   <= '0;
      r_ar_cnt     <= '0;
      r_mode_cl    <= CAS_LAT;
      r_mode_bl    <= BURST_LEN;
      r_cmd        <= CMD_NOP;
      r_addr       <= '1;
      r_bank       <= '1;
      r_init_end   <= 1'b0;
      r_reinit_ack <= 1'b0;
      r_mrs_ack    <= 1'b0;
    end else begin
      r_reinit_ack <= 1'b0;
      r_mrs_ack    <= 1'b0;
      r_init_end   <= 1'b0;
      r_cmd        <= CMD_NOP;
      r_addr       <= '1;
      r_bank       <= '1;
      case (r_state)
        ST_WAIT: begin
          if (r_wait_cnt != WAIT_W'(T_WAIT)) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          if (r_wait_cnt == WAIT_W'(T_WAIT - 1)) r_state <= ST_PRE;
        end
        ST_PRE: begin
          r_cmd   <= CMD_PRE;
          r_state <= ST_TRP;
        end
        ST_TRP: begin
          if (w_tmr_done) r_state <= ST_AR;
        end
        ST_AR: begin
          r_cmd    <= CMD_AREF;
          r_ar_cnt <= r_ar_cnt + AR_W'(1);
          r_state  <= ST_TRFC;
        end
        ST_TRFC: begin
          if (w_tmr_done) r_state <= (r_ar_cnt < AR_W'(AR_NUM)) ? ST_AR : ST_MRS;
        end
        ST_MRS: begin
          r_cmd   <= CMD_MRS;
          r_bank  <= '0;
          r_addr  <= {{(ADDR_W-10){1'b0}},
                      build_mode(WR_BURST, r_mode_cl, BURST_TYPE, r_mode_bl)};
          r_state <= ST_TMRD;
        end
        ST_TMRD: begin
          if (w_tmr_done) r_state <= ST_DONE;
        end
        ST_DONE: begin
          // Reinit has priority; a concurrent mrs_req is left pending for the next DONE.
          if (reinit_req) begin
            r_reinit_ack <= 1'b1;
            r_ar_cnt     <= '0;
            r_state      <= ST_PRE;
          end else if (mrs_req) begin
            r_mrs_ack <= 1'b1;
            r_mode_cl <= mrs_cl;
            r_mode_bl <= mrs_bl;
            r_state   <= ST_MRS;
          end else begin
            r_init_end <= 1'b1;
          end
        end
        default: r_state <= ST_WAIT;
      endcase
    end
  end

  assign init_cmd   = r_cmd;
  assign init_addr  = r_addr;
  assign init_bank  = r_bank;
  assign init_end   = r_init_end;
  assign reinit_ack = r_reinit_ack;
  assign mrs_ack    = r_mrs_ack;
  assign cur_cl     = r_mode_cl;

endmodule

// File: tb/tb_sdram_init_gen.sv
// tb/tb_sdram_init_gen.sv - randomized self-checking bench for sdram_init_gen
module tb_sdram_init_gen;

  localparam int T_WAIT = 20;
  localparam int AR_NUM = 8;
  localparam int TRP    = 2;
  localparam int TRFC   = 7;
  localparam int TMRD   = 3;
  localparam int ADDR_W = 13;
  localparam int BANK_W = 2;
  // Offset of MRS from PRECHARGE in a full sequence.
  localparam int SEQ_M  = 1 + TRP + AR_NUM * (1 + TRFC);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              reinit_req = 1'b0;
  logic              mrs_req = 1'b0;
  logic [2:0]        mrs_cl = 3'd0;
  logic [2:0]        mrs_bl = 3'd0;
  logic              reinit_ack;
  logic              mrs_ack;
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  logic [BANK_W-1:0] init_bank;
  logic              init_end;
  logic [2:0]        cur_cl;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  logic [2:0] m_cl = 3'd3;
  logic [2:0] m_bl = 3'b111;

  sdram_init_gen #(
    .T_WAIT (T_WAIT), .AR_NUM (AR_NUM), .TRP (TRP), .TRFC (TRFC), .TMRD (TMRD),
    .ADDR_W (ADDR_W), .BANK_W (BANK_W), .CAS_LAT (3'd3), .BURST_LEN (3'b111),
    .BURST_TYPE (1'b0), .WR_BURST (1'b0)
  ) dut (
    .init_clk   (clk),
    .init_rst_n (rst_n),
    .reinit_req (reinit_req),
    .reinit_ack (reinit_ack),
    .mrs_req    (mrs_req),
    .mrs_cl     (mrs_cl),
    .mrs_bl     (mrs_bl),
    .mrs_ack    (mrs_ack),
    .init_cmd   (init_cmd),
    .init_addr  (init_addr),
    .init_bank  (init_bank),
    .init_end   (init_end),
    .cur_cl     (cur_cl)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Expected command at a given offset from the first command of a sequence.
  function automatic logic [3:0] exp_cmd(input int off, input bit full);
    int m;
    m = full ? SEQ_M : 0;
    if (off == m) return 4'b0000;
    if (full && off == 0) return 4'b0010;
    if (full && off >= 1 + TRP && off < m && ((off - 1 - TRP) % (1 + TRFC)) == 0) return 4'b0001;
    return 4'b0111;
  endfunction

  function automatic logic [ADDR_W-1:0] exp_addr(input int off, input bit full,
                                                 input logic [2:0] cl, input logic [2:0] bl);
    if (exp_cmd(off, full) == 4'b0000) return {3'b000, 1'b0, 2'b00, cl, 1'b0, bl};
    return 13'h1FFF;
  endfunction

  // Steps from acceptance edge acc until the sequence ends, comparing every cycle.
  task automatic run_and_check_seq(input int acc, input bit full,
                                   input logic [2:0] cl, input logic [2:0] bl,
                                   input bit pend, input int raise,
                                   input logic [2:0] rcl, input logic [2:0] rbl,
                                   input string tag);
    int m, fin, off;
    logic [3:0] ec;
    logic [ADDR_W-1:0] ea;
    logic [BANK_W-1:0] eb;
    logic ee, em;
    m = full ? SEQ_M : 0;
    fin = m + 1 + TMRD;
    while (edge_n < acc + 1 + fin) begin
      step();
      off = edge_n - acc - 1;
      ec = exp_cmd(off, full);
      ea = exp_addr(off, full, cl, bl);
      eb = (ec == 4'b0000) ? 2'b00 : 2'b11;
      ee = (off == fin) && !pend;
      em = (off == fin) && pend;
      checks++;
      if ({init_cmd, init_addr, init_bank} !== {ec, ea, eb}) begin
        errors++;
        $display("FAIL %s bus edge %0d: got cmd=%b addr=%h bank=%b want cmd=%b addr=%h bank=%b",
                 tag, edge_n, init_cmd, init_addr, init_bank, ec, ea, eb);
      end
      checks++;
      if (init_end !== ee) begin
        errors++;
        $display("FAIL %s init_end edge %0d: got %b want %b", tag, edge_n, init_end, ee);
      end
      checks++;
      if ({reinit_ack, mrs_ack} !== {1'b0, em}) begin
        errors++;
        $display("FAIL %s acks edge %0d: got reinit=%b mrs=%b want reinit=0 mrs=%b",
                 tag, edge_n, reinit_ack, mrs_ack, em);
      end
      if (!em) begin
        checks++;
        if (cur_cl !== cl) begin
          errors++;
          $display("FAIL %s cur_cl edge %0d: got %0d want %0d", tag, edge_n, cur_cl, cl);
        end
      end
      if (raise > 0 && edge_n == raise - 1) begin
        mrs_req = 1'b1;
        mrs_cl  = rcl;
        mrs_bl  = rbl;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({init_cmd, init_addr, init_bank, init_end, reinit_ack, mrs_ack, cur_cl} !==
        {4'b0111, 13'h1FFF, 2'b11, 1'b0, 1'b0, 1'b0, 3'd3}) begin
      errors++;
      $display("FAIL %s: got cmd=%b addr=%h bank=%b end=%b acks=%b%b cl=%0d want 0111/1fff/11/0/00/3",
               tag, init_cmd, init_addr, init_bank, init_end, reinit_ack, mrs_ack, cur_cl);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_values");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
    m_cl = 3'd3;
    m_bl = 3'b111;
  endtask

  task automatic test_power_up();
    run_and_check_seq(T_WAIT, 1'b1, m_cl, m_bl, 1'b0, -1, 3'd0, 3'd0, "power_up");
  endtask

  task automatic test_mode_reload();
    int n;
    logic [2:0] cl, bl;
    for (int i = 0; i < 3; i++) begin
      cl = 3'($urandom_range(1, 3));
      bl = 3'($urandom_range(0, 7));
      n  = (i == 0) ? 0 : $urandom_range(1, 6);
      repeat (n) begin
        step();
        checks++;
        if ({init_end, init_cmd} !== 5'b1_0111) begin
          errors++;
          $display("FAIL idle edge %0d: got end=%b cmd=%b want end=1 cmd=0111", edge_n, init_end, init_cmd);
        end
      end
      mrs_req = 1'b1;
      mrs_cl  = cl;
      mrs_bl  = bl;
      step();
      checks++;
      if ({mrs_ack, reinit_ack, init_end} !== 3'b100) begin
        errors++;
        $display("FAIL reload_ack edge %0d: got mrs=%b reinit=%b end=%b want 1 0 0",
                 edge_n, mrs_ack, reinit_ack, init_end);
      end
      checks++;
      if (cur_cl !== cl) begin
        errors++;
        $display("FAIL reload_cur_cl edge %0d: got %0d want %0d", edge_n, cur_cl, cl);
      end
      mrs_req = 1'b0;
      mrs_cl  = 3'($urandom);
      mrs_bl  = 3'($urandom);
      m_cl = cl;
      m_bl = bl;
      run_and_check_seq(edge_n, 1'b0, cl, bl, 1'b0, -1, 3'd0, 3'd0, "reload");
    end
  endtask

  task automatic test_reinit();
    for (int i = 0; i < 2; i++) begin
      repeat ($urandom_range(0, 4)) step();
      reinit_req = 1'b1;
      step();
      checks++;
      if ({reinit_ack, mrs_ack, init_end} !== 3'b100) begin
        errors++;
        $display("FAIL reinit_ack edge %0d: got reinit=%b mrs=%b end=%b want 1 0 0",
                 edge_n, reinit_ack, mrs_ack, init_end);
      end
      reinit_req = 1'b0;
      run_and_check_seq(edge_n, 1'b1, m_cl, m_bl, 1'b0, -1, 3'd0, 3'd0, "reinit");
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] cl, bl;
    cl = 3'($urandom_range(1, 3));
    bl = 3'($urandom_range(0, 7));
    reinit_req = 1'b1;
    mrs_req    = 1'b1;
    mrs_cl     = cl;
    mrs_bl     = bl;
    step();
    checks++;
    if ({reinit_ack, mrs_ack, init_end} !== 3'b100) begin
      errors++;
      $display("FAIL both_first edge %0d: got reinit=%b mrs=%b end=%b want 1 0 0",
               edge_n, reinit_ack, mrs_ack, init_end);
    end
    reinit_req = 1'b0;
    run_and_check_seq(edge_n, 1'b1, m_cl, m_bl, 1'b1, -1, 3'd0, 3'd0, "both_reinit");
    checks++;
    if (cur_cl !== cl) begin
      errors++;
      $display("FAIL both_cur_cl edge %0d: got %0d want %0d", edge_n, cur_cl, cl);
    end
    mrs_req = 1'b0;
    m_cl = cl;
    m_bl = bl;
    run_and_check_seq(edge_n, 1'b0, cl, bl, 1'b0, -1, 3'd0, 3'd0, "both_mrs");
  endtask

  task automatic test_reset_mid();
    logic [2:0] cl, bl;
    int raise;
    reinit_req = 1'b1;
    step();
    reinit_req = 1'b0;
    repeat ($urandom_range(5, 60)) step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
    m_cl = 3'd3;
    m_bl = 3'b111;
    cl = 3'($urandom_range(1, 3));
    bl = 3'($urandom_range(0, 7));
    raise = $urandom_range(30, 85);
    run_and_check_seq(T_WAIT, 1'b1, m_cl, m_bl, 1'b1, raise, cl, bl, "req_in_seq");
    checks++;
    if (cur_cl !== cl) begin
      errors++;
      $display("FAIL req_in_seq_cur_cl edge %0d: got %0d want %0d", edge_n, cur_cl, cl);
    end
    mrs_req = 1'b0;
    m_cl = cl;
    m_bl = bl;
    run_and_check_seq(edge_n, 1'b0, cl, bl, 1'b0, -1, 3'd0, 3'd0, "req_in_seq_mrs");
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_mode_reload();
    test_reinit();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_init_gen.md
# sdram_init_gen

Parametrised SDRAM power-up initialisation sequencer: power-up wait, PRECHARGE ALL, N× AUTO REFRESH, then LOAD MODE REGISTER. Device timing, refresh count, address/bank widths and the mode word are parameters. After initialisation the block can re-run the full sequence or reload only the mode register (new CAS latency / burst length) through a req/ack handshake. It sits between the SDRAM top-level command mux and the arbiter; `init_end` gates the arbiter.

## Interface

**Parameters**
- `T_WAIT`, 20000: power-up wait in clocks (200 µs at 100 MHz); ≥ 2.
- `AR_NUM`, 8: AUTO REFRESH commands per sequence; ≥ 1.
- `TRP`, 2: tRP in clocks; ≥ 1.
- `TRFC`, 7: tRFC in clocks; ≥ 1.
- `TMRD`, 3: tMRD in clocks; ≥ 1.
- `ADDR_W`, 13: SDRAM address width; ≥ 11.
- `BANK_W`, 2: bank address width.
- `CAS_LAT`, 3'd3: initial CAS latency field.
- `BURST_LEN`, 3'b111: initial burst-length field (full page).
- `BURST_TYPE`, 1'b0: 0 = sequential, 1 = interleaved.
- `WR_BURST`, 1'b0: A9 value; 0 = burst write, 1 = single write.

**Ports**
- `init_clk`, in, 1: clock.
- `init_rst_n`, in, 1: reset. Asynchronous, active-low.
- `reinit_req`, in, 1: level request to re-run the sequence, skipping the power-up wait.
- `reinit_ack`, out, 1: one-cycle pulse when `reinit_req` is accepted.
- `mrs_req`, in, 1: level request to reload the mode register only.
- `mrs_cl`, in, 3: CAS latency for the reload; sampled on acceptance.
- `mrs_bl`, in, 3: burst length for the reload; sampled on acceptance.
- `mrs_ack`, out, 1: one-cycle pulse when `mrs_req` is accepted.
- `init_cmd`, out, 4: {cs_n, ras_n, cas_n, we_n}.
- `init_addr`, out, ADDR_W: SDRAM address.
- `init_bank`, out, BANK_W: SDRAM bank address.
- `init_end`, out, 1: high while the SDRAM is initialised and idle.
- `cur_cl`, out, 3: CAS latency currently programmed, for the read path.

## Operation

- **Command encodings:** NOP 0111, PRECHARGE 0010, AREF 0001, MRS 0000.
- **States:** WAIT, PRE, TRP, AR, TRFC, MRS, TMRD, DONE.
- **Transitions:**
  - WAIT→PRE when the wait counter reaches T_WAIT−1.
  - PRE→TRP.
  - TRP→AR after TRP cycles.
  - AR→TRFC; the AR counter increments.
  - TRFC→AR after TRFC cycles if the AR counter < AR_NUM, otherwise TRFC→MRS.
  - MRS→TMRD; TMRD→DONE after TMRD cycles.
- **Requests in DONE:**
  - `reinit_req`=1: DONE→PRE, AR counter cleared.
  - Else `mrs_req`=1: DONE→MRS; `mrs_cl`/`mrs_bl` latched into the mode register.
  - Both high: reinit wins; `mrs_req` stays pending and is accepted on the next DONE.
- Requests outside DONE are not accepted and not queued. The requester holds `req` until `ack`, then drops it. A `req` still high after `ack` is accepted again at the next DONE.
- **Outputs** are registered from the current state.
  - PRE: PRECHARGE, addr all-ones (A10=1, all banks), bank all-ones.
  - AR: AREF.
  - MRS: bank all-zeros, addr = {zeros[ADDR_W−1:10], WR_BURST, 2'b00, CL[2:0], BURST_TYPE, BL[2:0]}.
  - Every other state: NOP, addr all-ones, bank all-ones (including TRP).
- **Mode register** resets to {CAS_LAT, BURST_LEN}. `cur_cl` shows the latched CL from the acceptance edge onward.
- **Reset values:**
  - `init_cmd`=NOP, `init_addr`=all-ones, `init_bank`=all-ones.
  - `init_end`=0, both acks 0, `cur_cl`=CAS_LAT.
  - State WAIT, all counters 0.
- Asserting reset at any point aborts the sequence and restarts from WAIT, including the full power-up wait.

## Timing

Edge k is the k-th rising edge after reset release.

- PRECHARGE is visible after edge T_WAIT+1 for one cycle.
- PRECHARGE→first AREF: 1+TRP cycles.
- AREF→AREF and last AREF→MRS: 1+TRFC cycles each.
- MRS→`init_end` rising: 1+TMRD cycles.
- Acceptance at edge N:
  - `ack`=1 and `init_end`=0 after edge N; `ack` returns low after edge N+1.
  - The first command (PRECHARGE or MRS) appears after edge N+1.
- Each command lasts exactly one cycle; NOP fills all other cycles.
- Wait counter saturates at T_WAIT. Cycle counters are sized $clog2(max(TRP,TRFC,TMRD)+1). AR counter is sized $clog2(AR_NUM+1).

## Structure

- **Package `sdram_pkg`:** command encodings (NOP/PRECHARGE/AREF/MRS), state enum typedef, `sdram_cmd_t`, and the mode-word build function.
- **Sub-module `sdram_timer`:** loadable down-counter with a done flag, shared for tRP/tRFC/tMRD.
- The wait counter stays inline.

## Test plan

Parameters T_WAIT=20, AR_NUM=8, TRP=2, TRFC=7, TMRD=3, ADDR_W=13.

1. **Reset release:**
   - PRECHARGE after edge 21, addr 0x1FFF.
   - AREF after edges 24, 32, …, 80 (eight of them).
   - MRS after edge 88, addr 0x037, bank 0.
   - `init_end` rises after edge 92; NOP with addr/bank all-ones everywhere else.
2. **Mode reload:** `mrs_req`=1, `mrs_cl`=2, `mrs_bl`=3'b011 sampled at edge 100.
   - `mrs_ack` pulse and `init_end`=0 after edge 100; `cur_cl`=2.
   - MRS addr 0x023 after edge 101; `init_end` rises after edge 105.
3. **Reinit at edge N in DONE:**
   - `reinit_ack` after N.
   - PRECHARGE at N+1, AREFs at N+4 … N+60, MRS at N+68, `init_end` at N+72.
   - No power-up wait.
4. **Simultaneous requests:**
   - `reinit_req` and `mrs_req` both held in DONE: reinit is acked first.
   - `mrs_ack` follows the first edge after `init_end` returns.
5. **Request during sequence:**
   - `mrs_req` held from edge 50: no ack before edge 92.
   - Acceptance at edge 92; MRS after edge 93.
6. **Reset mid-sequence:**
   - `init_rst_n` low at edge 60: outputs return to reset values immediately.
   - On release, the sequence restarts with PRECHARGE after edge 21.
